// File: rtl/core_seq_pkg.sv
// Shared types and field positions for the attention-core instruction sequencer.
package core_seq_pkg;

    // Sequencer states; the encoding is also exported on the phase debug port.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LD_Q  = 3'd1,
        ST_LD_K  = 3'd2,
        ST_KLD   = 3'd3,
        ST_EXEC  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_DRAIN = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Instruction word layout as consumed by core.
    localparam int INST_W          = 27;
    localparam int INST_OFIFO_RD   = 16;
    localparam int INST_QK_ADD_LSB = 12;
    localparam int INST_P_ADD_LSB  = 8;
    localparam int INST_EXECUTE    = 7;
    localparam int INST_LOAD       = 6;
    localparam int INST_QMEM_RD    = 5;
    localparam int INST_QMEM_WR    = 4;
    localparam int INST_KMEM_RD    = 3;
    localparam int INST_KMEM_WR    = 2;
    localparam int INST_PMEM_RD    = 1;
    localparam int INST_PMEM_WR    = 0;

    // Beat/cycle counter width; also the width of both address fields.
    localparam int CNT_W = 4;

endpackage

// File: rtl/seq_counter.sv
// Beat/cycle counter with clear and enable; at_last flags count == last.
module seq_counter
    import core_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] count,
    output logic             at_last
);

    logic [CNT_W-1:0] count_reg;

    // Clear has priority over increment so a state entry always starts at index 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count   = count_reg;
    assign at_last = (count_reg == last);

endmodule

// File: rtl/core_sequencer.sv
// Instruction sequencer: loads Q/K from the host stream, then walks the core
// through K load, execute, latency wait and ofifo drain, one pass per start.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter  int col      = 8,
    parameter  int bw       = 4,
    parameter  int pr       = 8,
    parameter  int len_q    = 8,
    parameter  int exec_lat = 10,
    localparam int DW       = pr * bw * 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        n_q,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DW-1:0]     mem_in,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic [2:0]        phase
);

    // Exit indices; every compare is on the last index so cnt never wraps.
    // KLD runs one extra index: index col is the gap cycle before EXEC.
    localparam logic [CNT_W-1:0] K_LAST    = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] KLD_LAST  = CNT_W'(col);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(exec_lat - 1);

    state_t              state_reg, state_next;
    logic [3:0]          nq_reg, nq_next;
    logic [INST_W-1:0]   inst_reg, inst_next;
    logic [DW-1:0]       mem_in_reg, mem_in_next;

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_last;
    logic                cnt_at_last;
    logic                cnt_clear;
    logic                cnt_en;

    seq_counter u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .last    (cnt_last),
        .count   (cnt),
        .at_last (cnt_at_last)
    );

    // Next-state, next instruction word and counter control for the current state.
    always_comb begin
        state_next  = state_reg;
        nq_next     = nq_reg;
        inst_next   = '0;
        mem_in_next = mem_in_reg;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        cnt_last    = '0;
        in_ready    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start && (n_q != 4'd0) && (int'(n_q) <= len_q)) begin
                    state_next = ST_LD_Q;
                    nq_next    = n_q;
                    cnt_clear  = 1'b1;
                end
            end

            ST_LD_Q: begin
                in_ready = 1'b1;
                cnt_last = nq_reg - 4'd1;
                if (in_valid) begin
                    inst_next[INST_QMEM_WR]                  = 1'b1;
                    inst_next[INST_QK_ADD_LSB +: CNT_W]      = cnt;
                    mem_in_next                              = in_data;
                    if (cnt_at_last) begin
                        state_next = ST_LD_K;
                        cnt_clear  = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end

            ST_LD_K: begin
                in_ready = 1'b1;
                cnt_last = K_LAST;
                if (in_valid) begin
                    inst_next[INST_KMEM_WR]                  = 1'b1;
                    inst_next[INST_QK_ADD_LSB +: CNT_W]      = cnt;
                    mem_in_next                              = in_data;
                    if (cnt_at_last) begin
                        state_next = ST_KLD;
                        cnt_clear  = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end

            ST_KLD: begin
                cnt_last = KLD_LAST;
                if (cnt_at_last) begin
                    // Gap cycle: instruction word stays zero.
                    state_next = ST_EXEC;
                    cnt_clear  = 1'b1;
                end else begin
                    inst_next[INST_KMEM_RD]             = 1'b1;
                    inst_next[INST_LOAD]                = 1'b1;
                    inst_next[INST_QK_ADD_LSB +: CNT_W] = cnt;
                    cnt_en                              = 1'b1;
                end
            end

            ST_EXEC: begin
                cnt_last                            = nq_reg - 4'd1;
                inst_next[INST_QMEM_RD]             = 1'b1;
                inst_next[INST_EXECUTE]             = 1'b1;
                inst_next[INST_QK_ADD_LSB +: CNT_W] = cnt;
                if (cnt_at_last) begin
                    state_next = ST_WAIT;
                    cnt_clear  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_WAIT: begin
                cnt_last = WAIT_LAST;
                if (cnt_at_last) begin
                    state_next = ST_DRAIN;
                    cnt_clear  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_DRAIN: begin
                cnt_last                           = nq_reg - 4'd1;
                inst_next[INST_OFIFO_RD]           = 1'b1;
                inst_next[INST_PMEM_WR]            = 1'b1;
                inst_next[INST_P_ADD_LSB +: CNT_W] = cnt;
                if (cnt_at_last) begin
                    state_next = ST_DONE;
                    cnt_clear  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
                cnt_clear  = 1'b1;
            end

            default: begin
                state_next = ST_IDLE;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    // State, latched Q count and the registered core-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            nq_reg     <= 4'd0;
            inst_reg   <= '0;
            mem_in_reg <= '0;
        end else begin
            state_reg  <= state_next;
            nq_reg     <= nq_next;
            inst_reg   <= inst_next;
            mem_in_reg <= mem_in_next;
        end
    end

    assign inst   = inst_reg;
    assign mem_in = mem_in_reg;
    assign busy   = (state_reg != ST_IDLE);
    assign done   = (state_reg == ST_DONE);
    assign phase  = state_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: randomized passes against an expected
// instruction trace built from the pass recipe, plus a small core model whose
// pmem result is compared to Q*K^T computed directly from the host vectors.
module tb_core_sequencer;

    localparam int COL      = 8;
    localparam int BW       = 4;
    localparam int PR       = 8;
    localparam int LEN_Q    = 8;
    localparam int EXEC_LAT = 10;
    localparam int DW       = PR * BW * 2;

    localparam int K_NONE  = 0;
    localparam int K_QWR   = 1;
    localparam int K_KWR   = 2;
    localparam int K_LOAD  = 3;
    localparam int K_EXEC  = 4;
    localparam int K_DRAIN = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    n_q;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] mem_in;
    logic [26:0]   inst;
    logic          busy;
    logic          done;
    logic [2:0]    phase;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    core_sequencer #(
        .col(COL), .bw(BW), .pr(PR), .len_q(LEN_Q), .exec_lat(EXEC_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .n_q(n_q),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_in(mem_in), .inst(inst), .busy(busy), .done(done), .phase(phase)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Instruction word for one kind of core operation, built from the field map.
    function automatic logic [26:0] mk(input int kind, input int addr);
        logic [26:0] w;
        logic [3:0]  a;
        w = '0;
        a = 4'(addr);
        case (kind)
            K_QWR:   begin w[4] = 1'b1; w[15:12] = a; end
            K_KWR:   begin w[2] = 1'b1; w[15:12] = a; end
            K_LOAD:  begin w[6] = 1'b1; w[3] = 1'b1; w[15:12] = a; end
            K_EXEC:  begin w[7] = 1'b1; w[5] = 1'b1; w[15:12] = a; end
            K_DRAIN: begin w[16] = 1'b1; w[0] = 1'b1; w[11:8] = a; end
            default: w = '0;
        endcase
        return w;
    endfunction

    // Expected per-cycle trace of one pass, index 0 = first cycle after start.
    logic [26:0]   e_inst[$];
    logic [DW-1:0] e_mem[$];
    logic [DW-1:0] e_dat[$];
    bit            e_vld[$];
    bit            e_ld[$];
    logic [DW-1:0] model_mem;
    logic [DW-1:0] qv[LEN_Q];
    logic [DW-1:0] kv[COL];

    task automatic push(input int kind, input int addr, input bit v, input logic [DW-1:0] d, input bit ld);
        e_inst.push_back(mk(kind, addr));
        e_vld.push_back(v);
        e_dat.push_back(d);
        e_ld.push_back(ld);
        if (ld && v) model_mem = d;
        e_mem.push_back(model_mem);
    endtask

    // pct < 0 selects a strict 1,0,1,0 valid pattern during loading.
    task automatic build(input int nq, input int pct, output int exec_idx);
        bit            tog;
        bit            v;
        logic [DW-1:0] d;
        int            n;
        e_inst.delete(); e_mem.delete(); e_dat.delete(); e_vld.delete(); e_ld.delete();
        tog = 1'b0;
        for (int ph = 0; ph < 2; ph++) begin
            n = (ph == 0) ? nq : COL;
            for (int b = 0; b < n; b++) begin
                v = 1'b0;
                while (!v) begin
                    v = (pct < 0) ? !tog : (int'($urandom_range(99)) < pct);
                    if (pct < 0) tog = v;
                    d = {$urandom, $urandom};
                    push(v ? ((ph == 0) ? K_QWR : K_KWR) : K_NONE, b, v, d, 1'b1);
                    if (v && ph == 0) qv[b] = d;
                    if (v && ph == 1) kv[b] = d;
                end
            end
        end
        for (int j = 0; j < COL; j++) push(K_LOAD, j, 1'($urandom_range(1)), {$urandom, $urandom}, 1'b0);
        push(K_NONE, 0, 1'($urandom_range(1)), {$urandom, $urandom}, 1'b0);
        exec_idx = e_inst.size();
        for (int j = 0; j < nq; j++) push(K_EXEC, j, 1'($urandom_range(1)), {$urandom, $urandom}, 1'b0);
        for (int j = 0; j < EXEC_LAT; j++) push(K_NONE, 0, 1'($urandom_range(1)), {$urandom, $urandom}, 1'b0);
        for (int j = 0; j < nq; j++) push(K_DRAIN, j, 1'($urandom_range(1)), {$urandom, $urandom}, 1'b0);
        push(K_NONE, 0, 1'($urandom_range(1)), {$urandom, $urandom}, 1'b0);
    endtask

    // Behavioural core: reacts to inst/mem_in as core would, fills pmem.
    logic [DW-1:0] c_q[16];
    logic [DW-1:0] c_k[16];
    logic [DW-1:0] c_a[16];
    logic [127:0]  pmem[16];
    logic [127:0]  ofifo[$];

    function automatic logic [127:0] core_row(input logic [DW-1:0] q);
        logic [127:0] r;
        logic [15:0]  s;
        r = '0;
        for (int c = 0; c < COL; c++) begin
            s = '0;
            for (int e = 0; e < PR; e++) s = s + 16'(q[e*BW +: BW]) * 16'(c_a[c][e*BW +: BW]);
            r[c*16 +: 16] = s;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            ofifo.delete();
        end else begin
            if (inst[4]) c_q[inst[15:12]] = mem_in;
            if (inst[2]) c_k[inst[15:12]] = mem_in;
            if (inst[6]) c_a[inst[15:12]] = c_k[inst[15:12]];
            if (inst[7]) ofifo.push_back(core_row(c_q[inst[15:12]]));
            if (inst[16] && inst[0] && ofifo.size() > 0) pmem[inst[11:8]] = ofifo.pop_front();
        end
    end

    // One pass: start, walk the expected trace cycle by cycle, optionally abort by reset in EXEC.
    task automatic run_pass(input int nq, input int pct, input bit abort, input bit noise);
        int          ei;
        int          len;
        logic [15:0] g;
        build(nq, pct, ei);
        len = e_inst.size();
        @(negedge clk);
        start    = 1'b1;
        n_q      = 4'(nq);
        in_valid = 1'($urandom_range(1));
        in_data  = {$urandom, $urandom};
        @(negedge clk);
        check("accept_busy", 64'(busy), 64'(1));
        check("accept_ready", 64'(in_ready), 64'(1));
        check("accept_inst", 64'(inst), 64'(0));
        for (int i = 0; i < len; i++) begin
            in_valid = e_vld[i];
            in_data  = e_dat[i];
            start    = noise && ($urandom_range(3) == 0);
            n_q      = 4'($urandom_range(8, 1));
            reset    = abort && (i == ei + 3);
            @(negedge clk);
            if (abort && i == ei + 3) begin
                check("abort_inst", 64'(inst), 64'(0));
                check("abort_busy", 64'(busy), 64'(0));
                check("abort_done", 64'(done), 64'(0));
                check("abort_phase", 64'(phase), 64'(0));
                check("abort_mem", mem_in, 64'(0));
                reset     = 1'b0;
                start     = 1'b0;
                model_mem = '0;
                return;
            end
            check($sformatf("inst[%0d]", i), 64'(inst), 64'(e_inst[i]));
            check($sformatf("mem_in[%0d]", i), mem_in, e_mem[i]);
            check($sformatf("busy[%0d]", i), 64'(busy), 64'(i < len - 1));
            check($sformatf("done[%0d]", i), 64'(done), 64'(i == len - 2));
            check($sformatf("ready[%0d]", i), 64'(in_ready), 64'((i + 1 < len) && e_ld[i + 1]));
        end
        start    = 1'b0;
        in_valid = 1'b0;
        for (int r = 0; r < nq; r++) begin
            for (int c = 0; c < COL; c++) begin
                g = '0;
                for (int e = 0; e < PR; e++) g = g + 16'(qv[r][e*BW +: BW]) * 16'(kv[c][e*BW +: BW]);
                check($sformatf("pmem[%0d][%0d]", r, c), 64'(pmem[r][c*16 +: 16]), 64'(g));
            end
        end
        $display("pass n_q=%0d pct=%0d abort=%0d cycles=%0d", nq, pct, abort, len);
    endtask

    task automatic bad_start(input int nq);
        @(negedge clk);
        start = 1'b1;
        n_q   = 4'(nq);
        @(negedge clk);
        start = 1'b0;
        check($sformatf("bad_start%0d_busy", nq), 64'(busy), 64'(0));
        check($sformatf("bad_start%0d_inst", nq), 64'(inst), 64'(0));
        @(negedge clk);
        check($sformatf("bad_start%0d_busy2", nq), 64'(busy), 64'(0));
        check($sformatf("bad_start%0d_done", nq), 64'(done), 64'(0));
        check($sformatf("bad_start%0d_inst2", nq), 64'(inst), 64'(0));
        $display("ignored start n_q=%0d", nq);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        n_q       = 4'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        model_mem = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_inst", 64'(inst), 64'(0));
        check("rst_mem", mem_in, 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(0));
        check("rst_phase", 64'(phase), 64'(0));

        run_pass(8, 100, 1'b0, 1'b0);
        run_pass(4, -1, 1'b0, 1'b0);
        bad_start(0);
        bad_start(9);
        bad_start(15);
        run_pass(6, 70, 1'b0, 1'b1);
        run_pass(5, 80, 1'b1, 1'b0);
        run_pass(8, 60, 1'b0, 1'b1);
        run_pass(1, 100, 1'b0, 1'b0);
        repeat (4) run_pass(int'($urandom_range(8, 1)), int'($urandom_range(100, 30)), 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
